// File: rtl/fir_mac_seq_pkg.sv
// Shared DSP definitions for the sequenced FIR stage and its neighbouring filter stages.
//   acc_width() : accumulator width for an 11-bit sample times a CW-bit coefficient,
//                 with 6 guard bits so that 64 taps can never overflow.
//   round_sat() : round-half-up arithmetic right shift, then saturate to a signed width.
//   IDLE/RUN/DRAIN : sequencer state encoding.
package fir_mac_seq_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    function automatic int unsigned acc_width(input int unsigned cw);
        return 11 + cw + 6;
    endfunction

    // Operates on a 64-bit sign-extended accumulator; the caller truncates to its width.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int unsigned      shift,
                                                     input int unsigned      ow);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/srl64x11e.sv
// 64-deep, 11-bit wide shift register with clock enable and random-access read.
//   clk_i : clock
//   ce_i  : shift enable; d_i enters at address 0, older entries move up by one
//   d_i   : sample to shift in
//   a_i   : read address (0 = newest)
//   y_o   : combinational read data at a_i
// Contents are intentionally not reset.
module srl64x11e (
    input  logic        clk_i,
    input  logic        ce_i,
    input  logic [10:0] d_i,
    input  logic [5:0]  a_i,
    output logic [10:0] y_o
);

    logic [10:0] mem_q [64];

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            mem_q[0] <= d_i;
            for (int i = 1; i < 64; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign y_o = mem_q[a_i];

endmodule

// File: rtl/fir_mac_seq.sv
// Sequenced single-multiplier FIR filter. Each accepted sample is shifted into a 64x11
// delay line, then one tap per clock is multiply-accumulated against an external
// registered coefficient ROM. One rounded, saturated result is produced per sample.
//   clk, rst   : clock, asynchronous active-high reset
//   di_i/di_v_i: signed input sample and its strobe
//   di_rdy_o   : an input will be accepted this cycle
//   ca_o       : coefficient ROM address (coef_i valid the following cycle)
//   coef_i     : signed coefficient
//   do_o/do_v_o: signed result (held) and its one-cycle strobe
//   busy_o     : sequencer not idle
//   lost_o     : sticky, a sample arrived while not ready
module fir_mac_seq
    import fir_mac_seq_pkg::*;
#(
    parameter int unsigned NTAPS  = 64,
    parameter int unsigned CW     = 18,
    parameter int unsigned OW     = 16,
    parameter int unsigned OSHIFT = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   di_i,
    input  logic          di_v_i,
    output logic          di_rdy_o,
    output logic [5:0]    ca_o,
    input  logic [CW-1:0] coef_i,
    output logic [OW-1:0] do_o,
    output logic          do_v_o,
    output logic          busy_o,
    output logic          lost_o
);

    localparam int unsigned AW    = acc_width(CW);
    localparam int unsigned PW    = 11 + CW;
    localparam logic [5:0]  KLAST = 6'(NTAPS - 1);

    logic [1:0]           state_q, state_d;
    logic [5:0]           k_q, k_d;
    logic                 ce;
    logic [10:0]          tap_y;

    logic signed [10:0]   s_q;
    logic                 s_v_q, s_first_q, s_last_q;
    logic signed [PW-1:0] p_q, p_d;
    logic                 p_v_q, p_first_q, p_last_q;
    logic signed [AW-1:0] acc_q, acc_d, p_ext;
    logic                 acc_last_q;
    logic [OW-1:0]        do_q, do_d;
    logic                 do_v_q;
    logic                 lost_q;

    assign ce = (state_q == IDLE) && di_v_i;

    srl64x11e u_dly (
        .clk_i (clk),
        .ce_i  (ce),
        .d_i   (di_i),
        .a_i   (k_q),
        .y_o   (tap_y)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                k_d = 6'd0;
                if (di_v_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (k_q == KLAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            DRAIN: begin
                // Leave as the last product lands, so IDLE coincides with do_v.
                if (acc_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p_d   = PW'(s_q) * PW'($signed(coef_i));
        p_ext = {{(AW - PW){p_q[PW-1]}}, p_q};
        acc_d = acc_q;
        if (p_v_q) begin
            acc_d = p_first_q ? p_ext : acc_q + p_ext;
        end
        do_d = do_q;
        if (acc_last_q) begin
            do_d = OW'(round_sat({{(64 - AW){acc_q[AW-1]}}, acc_q}, OSHIFT, OW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= 6'd0;
            s_q        <= '0;
            s_v_q      <= 1'b0;
            s_first_q  <= 1'b0;
            s_last_q   <= 1'b0;
            p_q        <= '0;
            p_v_q      <= 1'b0;
            p_first_q  <= 1'b0;
            p_last_q   <= 1'b0;
            acc_q      <= '0;
            acc_last_q <= 1'b0;
            do_q       <= '0;
            do_v_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            // Tap valid/first/last flags travel alongside the data through the pipe.
            s_q        <= tap_y;
            s_v_q      <= (state_q == RUN);
            s_first_q  <= (k_q == 6'd0);
            s_last_q   <= (k_q == KLAST);
            p_q        <= p_d;
            p_v_q      <= s_v_q;
            p_first_q  <= s_first_q;
            p_last_q   <= s_last_q;
            acc_q      <= acc_d;
            acc_last_q <= p_v_q && p_last_q;
            do_q       <= do_d;
            do_v_q     <= acc_last_q;
            if (di_v_i && (state_q != IDLE)) begin
                lost_q <= 1'b1;
            end
        end
    end

    assign di_rdy_o = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign ca_o     = k_q;
    assign do_o     = do_q;
    assign do_v_o   = do_v_q;
    assign lost_o   = lost_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq. Three instances share clock, reset and sample stimulus:
//   a: NTAPS=64, OSHIFT=0, OW=24   b: defaults   c: NTAPS=16, OSHIFT=0, OW=24
// Each has its own registered coefficient ROM.
module tb_fir_mac_seq;

    logic clk = 1'b0;
    logic rst;
    logic signed [10:0] di;
    logic di_v;

    logic        di_rdy_a, do_v_a, busy_a, lost_a;
    logic [5:0]  ca_a;
    logic [17:0] coef_a;
    logic [23:0] do_a;
    logic        di_rdy_b, do_v_b, busy_b, lost_b;
    logic [5:0]  ca_b;
    logic [17:0] coef_b;
    logic [15:0] do_b;
    logic        di_rdy_c, do_v_c, busy_c, lost_c;
    logic [5:0]  ca_c;
    logic [17:0] coef_c;
    logic [23:0] do_c;

    logic [17:0] rom_a [64];
    logic [17:0] rom_b [64];
    logic [17:0] rom_c [64];

    int n_checks = 0;
    int n_fail   = 0;
    int max_ca_c = 0;
    int lat_a, lat_b, lat_c;
    logic signed [23:0] res_a, res_c;
    logic signed [15:0] res_b;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        coef_a <= rom_a[ca_a];
        coef_b <= rom_b[ca_b];
        coef_c <= rom_c[ca_c];
        if (int'(ca_c) > max_ca_c) max_ca_c = int'(ca_c);
    end

    fir_mac_seq #(.NTAPS(64), .CW(18), .OW(24), .OSHIFT(0)) u_dut_a (
        .clk(clk), .rst(rst), .di_i(di), .di_v_i(di_v), .di_rdy_o(di_rdy_a), .ca_o(ca_a),
        .coef_i(coef_a), .do_o(do_a), .do_v_o(do_v_a), .busy_o(busy_a), .lost_o(lost_a)
    );
    fir_mac_seq u_dut_b (
        .clk(clk), .rst(rst), .di_i(di), .di_v_i(di_v), .di_rdy_o(di_rdy_b), .ca_o(ca_b),
        .coef_i(coef_b), .do_o(do_b), .do_v_o(do_v_b), .busy_o(busy_b), .lost_o(lost_b)
    );
    fir_mac_seq #(.NTAPS(16), .CW(18), .OW(24), .OSHIFT(0)) u_dut_c (
        .clk(clk), .rst(rst), .di_i(di), .di_v_i(di_v), .di_rdy_o(di_rdy_c), .ca_o(ca_c),
        .coef_i(coef_c), .do_o(do_c), .do_v_o(do_v_c), .busy_o(busy_c), .lost_o(lost_c)
    );

    // Present one sample in the current cycle (cycle 0) and record, per instance, the cycle
    // in which do_v first appears and the value then on do. -1 means it never appeared.
    task automatic run_sample(input logic signed [10:0] x);
        di = x; di_v = 1'b1;
        lat_a = -1; lat_b = -1; lat_c = -1;
        @(posedge clk); #1;
        di_v = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (do_v_a && lat_a < 0) begin lat_a = cyc; res_a = do_a; end
            if (do_v_b && lat_b < 0) begin lat_b = cyc; res_b = do_b; end
            if (do_v_c && lat_c < 0) begin lat_c = cyc; res_c = do_c; end
            if (lat_a >= 0 && lat_b >= 0 && lat_c >= 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; di = '0; di_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (di_rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_di_rdy got %b want 1", di_rdy_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_checks++; if (do_v_a !== 1'b0) begin n_fail++; $display("FAIL reset_do_v got %b want 0", do_v_a); end
        n_checks++; if (do_a !== 24'd0) begin n_fail++; $display("FAIL reset_do got %0d want 0", do_a); end
        n_checks++; if (lost_a !== 1'b0) begin n_fail++; $display("FAIL reset_lost got %b want 0", lost_a); end
        n_checks++; if (ca_a !== 6'd0) begin n_fail++; $display("FAIL reset_ca got %0d want 0", ca_a); end
        n_checks++; if (di_rdy_b !== 1'b1) begin n_fail++; $display("FAIL reset_di_rdy_b got %b want 1", di_rdy_b); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_impulse;
        int exp_a, exp_c;
        for (int k = 0; k < 64; k++) begin
            rom_a[k] = 18'(k + 1);
            rom_b[k] = 18'd0;
            rom_c[k] = 18'(k + 1);
        end
        repeat (64) run_sample(11'sd0);
        for (int n = 0; n <= 64; n++) begin
            run_sample((n == 0) ? 11'sd1 : 11'sd0);
            exp_a = (n < 64) ? n + 1 : 0;
            exp_c = (n < 16) ? n + 1 : 0;
            n_checks++; if (res_a !== 24'(exp_a)) begin n_fail++; $display("FAIL impulse_a n=%0d got %0d want %0d", n, res_a, exp_a); end
            n_checks++; if (lat_a != 68) begin n_fail++; $display("FAIL impulse_a_lat n=%0d got %0d want 68", n, lat_a); end
            n_checks++; if (res_c !== 24'(exp_c)) begin n_fail++; $display("FAIL impulse_c n=%0d got %0d want %0d", n, res_c, exp_c); end
            n_checks++; if (lat_c != 20) begin n_fail++; $display("FAIL impulse_c_lat n=%0d got %0d want 20", n, lat_c); end
        end
        n_checks++; if (di_rdy_a !== 1'b1) begin n_fail++; $display("FAIL impulse_rdy_at_do_v got %b want 1", di_rdy_a); end
        n_checks++; if (max_ca_c > 15) begin n_fail++; $display("FAIL ntaps16_ca_max got %0d want <=15", max_ca_c); end
    endtask

    task automatic test_dc_gain;
        for (int k = 0; k < 64; k++) begin
            rom_a[k] = 18'd1;
            rom_b[k] = 18'd1;
        end
        for (int i = 0; i < 64; i++) begin
            run_sample(11'sd1023);
            if (i == 0) begin
                n_checks++; if (res_a !== 24'd1023) begin n_fail++; $display("FAIL dc_first_a got %0d want 1023", res_a); end
            end
        end
        n_checks++; if (res_a !== 24'd65472) begin n_fail++; $display("FAIL dc_gain_a got %0d want 65472", res_a); end
        n_checks++; if (res_b !== 16'd0) begin n_fail++; $display("FAIL dc_gain_b got %0d want 0", res_b); end
        n_checks++; if (lat_b != 68) begin n_fail++; $display("FAIL dc_lat_b got %0d want 68", lat_b); end
    endtask

    task automatic test_round_sat;
        for (int k = 0; k < 64; k++) rom_b[k] = 18'd0;
        rom_b[0] = 18'd65536;
        run_sample(11'sd1);
        n_checks++; if (res_b !== 16'd1) begin n_fail++; $display("FAIL round_up got %0d want 1", res_b); end
        rom_b[0] = 18'd65535;
        run_sample(11'sd1);
        n_checks++; if (res_b !== 16'd0) begin n_fail++; $display("FAIL round_down got %0d want 0", res_b); end
        for (int k = 0; k < 64; k++) rom_b[k] = 18'h20000;
        for (int i = 0; i < 64; i++) begin
            run_sample(-11'sd1024);
            // Line holds -1024, 1, 1, 61 x 1023: sum 61381 times -2^17 -> clamps low.
            if (i == 0) begin
                n_checks++; if (res_b !== 16'sh8000) begin n_fail++; $display("FAIL sat_neg got %0d want -32768", res_b); end
            end
        end
        n_checks++; if (res_b !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos got %0d want 32767", res_b); end
    endtask

    task automatic test_overrun;
        // Instance a line: 64 x -1024, coefficients all 1.
        di = 11'sd5; di_v = 1'b1;
        lat_a = -1;
        @(posedge clk); #1;
        di_v = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc == 1) begin
                n_checks++; if (lost_a !== 1'b0) begin n_fail++; $display("FAIL overrun_lost_before got %b want 0", lost_a); end
            end
            if (cyc == 10) begin
                di = 11'sd7; di_v = 1'b1;
                n_checks++; if (di_rdy_a !== 1'b0) begin n_fail++; $display("FAIL overrun_di_rdy got %b want 0", di_rdy_a); end
            end
            if (cyc == 11) begin
                di_v = 1'b0;
                n_checks++; if (lost_a !== 1'b1) begin n_fail++; $display("FAIL overrun_lost got %b want 1", lost_a); end
            end
            if (do_v_a && lat_a < 0) begin lat_a = cyc; res_a = do_a; end
            if (lat_a >= 0) break;
            @(posedge clk); #1;
        end
        n_checks++; if (lat_a != 68) begin n_fail++; $display("FAIL overrun_lat got %0d want 68", lat_a); end
        n_checks++; if (res_a !== -24'sd64507) begin n_fail++; $display("FAIL overrun_result got %0d want -64507", res_a); end
        run_sample(11'sd0);
        n_checks++; if (res_a !== -24'sd63483) begin n_fail++; $display("FAIL overrun_next got %0d want -63483", res_a); end
        n_checks++; if (lost_a !== 1'b1) begin n_fail++; $display("FAIL overrun_lost_sticky got %b want 1", lost_a); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        di = 11'sd2; di_v = 1'b1;
        @(posedge clk); #1;
        di_v = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (do_a !== 24'd0) begin n_fail++; $display("FAIL midrst_do got %0d want 0", do_a); end
        n_checks++; if (lost_a !== 1'b0) begin n_fail++; $display("FAIL midrst_lost got %b want 0", lost_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (di_rdy_a !== 1'b1) begin n_fail++; $display("FAIL midrst_di_rdy got %b want 1", di_rdy_a); end
        seen = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (do_v_a || do_v_b || do_v_c) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_do_v got %b want 0", seen); end
        // Line now: 3, 2, 0, 5, 60 x -1024.
        run_sample(11'sd3);
        n_checks++; if (res_a !== -24'sd61430) begin n_fail++; $display("FAIL midrst_next got %0d want -61430", res_a); end
        n_checks++; if (lat_a != 68) begin n_fail++; $display("FAIL midrst_lat got %0d want 68", lat_a); end
    endtask

    initial begin
        rst = 1'b1; di = '0; di_v = 1'b0;
        for (int k = 0; k < 64; k++) begin
            rom_a[k] = 18'd0;
            rom_b[k] = 18'd0;
            rom_c[k] = 18'd0;
        end
        test_reset;
        test_impulse;
        test_dc_gain;
        test_round_sat;
        test_overrun;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
